// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response ports and RAM-side port of the shared memory arbiter.
// slave: arbiter view; master: core + RAM view.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, one access at a time.
// Tie policy: fixed data priority by default, alternating when ARB_ROUND_ROBIN_EN is defined.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_W      = 32
) (
    input  logic                clock_i,
    input  logic                reset_i,
    mem_port_arbiter_if.slave   bus,
    output logic                busy_o
);

    // state  | meaning
    // IDLE   | no access in flight, requests sampled
    // ACCESS | one-cycle address phase, mem_en high
    // WAIT   | counting down RAM latency, capture at zero
    // RESP   | one-cycle ack to granted port, requests sampled
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              tie_data;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= GNT_FETCH;
            gnt_q        <= GNT_FETCH;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_data = (last_grant_q == GNT_FETCH);
`else
    // History is tracked in both builds; fixed priority always hands ties to data.
    assign tie_data = last_grant_q | 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (bus.d_req && (!bus.if_req || tie_data)) begin
                    state_d      = ST_ACCESS;
                    gnt_d        = GNT_DATA;
                    last_grant_d = GNT_DATA;
                    we_d         = bus.d_we;
                    addr_d       = bus.d_addr;
                    wdata_d      = bus.d_wdata;
                end else if (bus.if_req) begin
                    state_d      = ST_ACCESS;
                    gnt_d        = GNT_FETCH;
                    last_grant_d = GNT_FETCH;
                    we_d         = 1'b0;
                    addr_d       = bus.if_addr;
                    wdata_d      = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (gnt_q == GNT_FETCH) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic in_access;
    logic in_resp;

    assign in_access     = (state_q == ST_ACCESS);
    assign in_resp       = (state_q == ST_RESP);

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access & we_q;
    assign bus.mem_addr  = in_access ? addr_q : '0;
    assign bus.mem_wdata = in_access ? wdata_q : '0;

    assign bus.if_ack    = in_resp && (gnt_q == GNT_FETCH);
    assign bus.d_ack     = in_resp && (gnt_q == GNT_DATA);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    assign busy_o        = (state_q != ST_IDLE);

endmodule
